// File: rtl/ascon_sbox_pkg.sv
// Shared Ascon 5-bit S-box definitions and sequencer state type for the
// iterative substitution layer.
package ascon_sbox_pkg;

    localparam int SBOX_W = 5;
    localparam int SBOX_N = 32;

    typedef logic [SBOX_W-1:0] sbox_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } seq_state_t;

    localparam sbox_t ASCON_SBOX [SBOX_N] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
    };

    function automatic sbox_t ascon_sbox(input sbox_t x);
        return ASCON_SBOX[x];
    endfunction

endpackage

// File: rtl/sub_layer_lut_seq_if.sv
// Handshake, state and table-port bundle between the round controller and
// the iterative substitution layer.
interface sub_layer_lut_seq_if #(
    parameter int WORD_W = 64
);
    logic              in_valid_i;
    logic              in_ready_o;
    logic              use_lut_i;
    logic [WORD_W-1:0] x0_i;
    logic [WORD_W-1:0] x1_i;
    logic [WORD_W-1:0] x2_i;
    logic [WORD_W-1:0] x3_i;
    logic [WORD_W-1:0] x4_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [WORD_W-1:0] x0_o;
    logic [WORD_W-1:0] x1_o;
    logic [WORD_W-1:0] x2_o;
    logic [WORD_W-1:0] x3_o;
    logic [WORD_W-1:0] x4_o;
    logic              lut_we_i;
    logic [4:0]        lut_addr_i;
    logic [4:0]        lut_wdata_i;
    logic              lut_gnt_o;
    logic [4:0]        lut_rdata_o;
    logic              busy_o;

    modport slave (
        input  in_valid_i, use_lut_i, x0_i, x1_i, x2_i, x3_i, x4_i,
        input  out_ready_i, lut_we_i, lut_addr_i, lut_wdata_i,
        output in_ready_o, out_valid_o, x0_o, x1_o, x2_o, x3_o, x4_o,
        output lut_gnt_o, lut_rdata_o, busy_o
    );

    modport master (
        output in_valid_i, use_lut_i, x0_i, x1_i, x2_i, x3_i, x4_i,
        output out_ready_i, lut_we_i, lut_addr_i, lut_wdata_i,
        input  in_ready_o, out_valid_o, x0_o, x1_o, x2_o, x3_o, x4_o,
        input  lut_gnt_o, lut_rdata_o, busy_o
    );

endinterface

// File: rtl/sbox_lut_bank.sv
// Programmable 32x5 substitution table, reset to the Ascon S-box, with one
// write port, LANES datapath read ports and one debug read port.
module sbox_lut_bank
    import ascon_sbox_pkg::*;
#(
    parameter int LANES = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic                      i_we,
    input  sbox_t                     i_waddr,
    input  sbox_t                     i_wdata,
    input  logic [LANES*SBOX_W-1:0]   i_rd_addr,
    output logic [LANES*SBOX_W-1:0]   o_rd_data,
    input  sbox_t                     i_dbg_addr,
    output sbox_t                     o_dbg_data
);

    sbox_t r_table [SBOX_N];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_table <= ASCON_SBOX;
        end else if (i_we) begin
            r_table[i_waddr] <= i_wdata;
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_rd
        assign o_rd_data[l*SBOX_W +: SBOX_W] = r_table[i_rd_addr[l*SBOX_W +: SBOX_W]];
    end

    assign o_dbg_data = r_table[i_dbg_addr];

endmodule

// File: rtl/sub_layer_lut_seq.sv
// Iterative Ascon substitution layer: LANES bit-columns per cycle through the
// fixed S-box or the programmable table, result returned over valid/ready.
//
// state   | meaning
// IDLE    | ready for a new state; table writes granted
// BUSY    | substituting slice r_cnt in place; table writes held off
// DONE    | result valid, waiting for out_ready_i; table writes granted
module sub_layer_lut_seq
    import ascon_sbox_pkg::*;
#(
    parameter int WORD_W = 64,
    parameter int LANES  = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    sub_layer_lut_seq_if.slave   bus
);

    localparam int N_SLICE = WORD_W / LANES;
    localparam int CNT_W   = (N_SLICE > 1) ? $clog2(N_SLICE) : 1;
    localparam int IDX_W   = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_SLICE - 1);

    if (LANES < 1 || LANES > WORD_W || (WORD_W % LANES) != 0) begin : g_bad_lanes
        $error("sub_layer_lut_seq: LANES must divide WORD_W and lie in 1..WORD_W");
    end

    seq_state_t                     r_state;
    logic [CNT_W-1:0]               r_cnt;
    logic                           r_use_lut;
    logic                           r_out_valid;
    logic                           r_busy;
    logic [SBOX_W-1:0][WORD_W-1:0]  r_x;

    logic [LANES*SBOX_W-1:0]        w_addr;
    logic [LANES*SBOX_W-1:0]        w_lut_data;
    logic [LANES*SBOX_W-1:0]        w_sub;
    logic                           w_lut_we;
    sbox_t                          w_dbg_data;

    function automatic logic [IDX_W-1:0] col_idx(input logic [CNT_W-1:0] cnt, input int lane);
        return IDX_W'(int'(cnt) * LANES + lane);
    endfunction

    // Address bit 4 is x0, bit 0 is x4; data bits map back the same way.
    always_comb begin
        w_addr = '0;
        for (int l = 0; l < LANES; l++) begin
            for (int b = 0; b < SBOX_W; b++) begin
                w_addr[l*SBOX_W + (SBOX_W-1-b)] = r_x[b][col_idx(r_cnt, l)];
            end
        end
    end

    always_comb begin
        w_sub = '0;
        for (int l = 0; l < LANES; l++) begin
            w_sub[l*SBOX_W +: SBOX_W] = r_use_lut ? w_lut_data[l*SBOX_W +: SBOX_W]
                                                  : ascon_sbox(w_addr[l*SBOX_W +: SBOX_W]);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_use_lut   <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_x         <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.in_valid_i) begin
                        r_x       <= {bus.x4_i, bus.x3_i, bus.x2_i, bus.x1_i, bus.x0_i};
                        r_use_lut <= bus.use_lut_i;
                        r_cnt     <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    for (int l = 0; l < LANES; l++) begin
                        for (int b = 0; b < SBOX_W; b++) begin
                            r_x[b][col_idx(r_cnt, l)] <= w_sub[l*SBOX_W + (SBOX_W-1-b)];
                        end
                    end
                    if (r_cnt == CNT_LAST) begin
                        r_busy      <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready_i) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Holding writes off during BUSY keeps the table constant across one substitution.
    assign w_lut_we = bus.lut_we_i && (r_state != ST_BUSY);

    sbox_lut_bank #(
        .LANES (LANES)
    ) u_bank (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .i_we       (w_lut_we),
        .i_waddr    (bus.lut_addr_i),
        .i_wdata    (bus.lut_wdata_i),
        .i_rd_addr  (w_addr),
        .o_rd_data  (w_lut_data),
        .i_dbg_addr (bus.lut_addr_i),
        .o_dbg_data (w_dbg_data)
    );

    assign bus.in_ready_o  = (r_state == ST_IDLE);
    assign bus.out_valid_o = r_out_valid;
    assign bus.busy_o      = r_busy;
    assign bus.lut_gnt_o   = w_lut_we;
    assign bus.lut_rdata_o = w_dbg_data;
    assign bus.x0_o        = r_x[0];
    assign bus.x1_o        = r_x[1];
    assign bus.x2_o        = r_x[2];
    assign bus.x3_o        = r_x[3];
    assign bus.x4_o        = r_x[4];

endmodule
